control_sequencer: RTL and testbench

//  Hardwired control FSM driving the bus datapath's strobes: fetches via PC/MAR/MDR, then executes

---
 rtl/ctrl_pkg.sv | 46 ++++
 rtl/ctrl_decode.sv | 39 +++
 rtl/control_sequencer.sv | 173 +++++++++++++++++
 tb/tb_control_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the control sequencer: opcodes, ALU one-hot bit indices,
// FSM state encoding and IR field positions.
package ctrl_pkg;

  localparam int CTRL_NREG  = 16;
  localparam int CTRL_ALU_W = 12;

  localparam logic [4:0] OP_ADD = 5'b01000;
  localparam logic [4:0] OP_SUB = 5'b01001;
  localparam logic [4:0] OP_AND = 5'b01010;
  localparam logic [4:0] OP_OR  = 5'b01011;
  localparam logic [4:0] OP_SHR = 5'b01100;
  localparam logic [4:0] OP_SHL = 5'b01101;
  localparam logic [4:0] OP_ROR = 5'b01110;
  localparam logic [4:0] OP_ROL = 5'b01111;
  localparam logic [4:0] OP_MUL = 5'b10000;
  localparam logic [4:0] OP_DIV = 5'b10001;
  localparam logic [4:0] OP_NEG = 5'b10010;
  localparam logic [4:0] OP_NOT = 5'b10011;

  localparam int B_ADD = 0;
  localparam int B_SUB = 1;
  localparam int B_AND = 2;
  localparam int B_OR  = 3;
  localparam int B_SHR = 4;
  localparam int B_SHL = 5;
  localparam int B_ROR = 6;
  localparam int B_ROL = 7;
  localparam int B_MUL = 8;
  localparam int B_DIV = 9;
  localparam int B_NEG = 10;
  localparam int B_NOT = 11;

  // IR field positions: [31:27] op, [26:23] Ra, [22:19] Rb, [18:15] Rc
  localparam int OP_MSB = 31;
  localparam int OP_LSB = 27;
  localparam int RA_MSB = 26;
  localparam int RA_LSB = 23;
  localparam int RB_MSB = 22;
  localparam int RB_LSB = 19;
  localparam int RC_MSB = 18;
  localparam int RC_LSB = 15;

  typedef enum logic [3:0] {IDLE, T0, T1, T2, T3, T4, T5, T6, ERR} state_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: ALU one-hot select plus legal/unary/mul-div flags.
// MUL and DIV decode as legal only when CTRL_MULDIV_EN is defined.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int ALU_W = CTRL_ALU_W
) (
  input  logic [4:0]       op,
  output logic [ALU_W-1:0] alu_ctrl,
  output logic             legal,
  output logic             is_unary,
  output logic             is_muldiv
);

  always_comb begin
    alu_ctrl  = '0;
    legal     = 1'b1;
    is_unary  = 1'b0;
    is_muldiv = 1'b0;
    case (op)
      OP_ADD: alu_ctrl[B_ADD] = 1'b1;
      OP_SUB: alu_ctrl[B_SUB] = 1'b1;
      OP_AND: alu_ctrl[B_AND] = 1'b1;
      OP_OR:  alu_ctrl[B_OR]  = 1'b1;
      OP_SHR: alu_ctrl[B_SHR] = 1'b1;
      OP_SHL: alu_ctrl[B_SHL] = 1'b1;
      OP_ROR: alu_ctrl[B_ROR] = 1'b1;
      OP_ROL: alu_ctrl[B_ROL] = 1'b1;
      OP_NEG: begin alu_ctrl[B_NEG] = 1'b1; is_unary = 1'b1; end
      OP_NOT: begin alu_ctrl[B_NOT] = 1'b1; is_unary = 1'b1; end
`ifdef CTRL_MULDIV_EN
      OP_MUL: begin alu_ctrl[B_MUL] = 1'b1; is_muldiv = 1'b1; end
      OP_DIV: begin alu_ctrl[B_DIV] = 1'b1; is_muldiv = 1'b1; end
`endif
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute control FSM for the bus datapath (Ra <= Rb op Rc).
// Define CTRL_MULDIV_EN to enable MUL/DIV with the extra T6 HI writeback state.
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int NREG  = CTRL_NREG,
  parameter int ALU_W = CTRL_ALU_W
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             run,
  input  logic             mem_rdy,
  input  logic [31:0]      ir,
  output logic [NREG-1:0]  rout,
  output logic [NREG-1:0]  rin,
  output logic             pc_out,
  output logic             pc_in,
  output logic             inc_pc,
  output logic             mar_in,
  output logic             ir_in,
  output logic             mdr_read,
  output logic             mdr_in,
  output logic             mdr_out,
  output logic             y_in,
  output logic             z_in,
  output logic             zlow_out,
  output logic             zhigh_out,
  output logic             lo_in,
  output logic             hi_in,
  output logic [ALU_W-1:0] alu_ctrl,
  output logic             instr_done,
  output logic             illegal
);

  state_t state_reg, state_next;
  logic             t1_wait_reg;
  logic             illegal_reg;
  logic [3:0]       ra_reg, rb_reg, rc_reg;
  logic [ALU_W-1:0] alu_reg;
  logic             unary_reg, muldiv_reg;

  logic [ALU_W-1:0] dec_alu;
  logic             dec_legal, dec_unary, dec_muldiv;
  logic [NREG-1:0]  ir_ra_oh, ir_rb_oh, ra_oh, rb_oh, rc_oh;
  logic             unused_ir;

  assign unused_ir = ^ir[RC_LSB-1:0];

  ctrl_decode #(.ALU_W(ALU_W)) u_decode (
    .op        (ir[OP_MSB:OP_LSB]),
    .alu_ctrl  (dec_alu),
    .legal     (dec_legal),
    .is_unary  (dec_unary),
    .is_muldiv (dec_muldiv)
  );

  // T3 reads the freshly loaded IR directly; later states use the fields captured in T3
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_onehot
      assign ir_ra_oh[gi] = (ir[RA_MSB:RA_LSB] == 4'(gi));
      assign ir_rb_oh[gi] = (ir[RB_MSB:RB_LSB] == 4'(gi));
      assign ra_oh[gi]    = (ra_reg == 4'(gi));
      assign rb_oh[gi]    = (rb_reg == 4'(gi));
      assign rc_oh[gi]    = (rc_reg == 4'(gi));
    end
  endgenerate

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_reg   <= IDLE;
      t1_wait_reg <= 1'b0;
      illegal_reg <= 1'b0;
      ra_reg      <= '0;
      rb_reg      <= '0;
      rc_reg      <= '0;
      alu_reg     <= '0;
      unary_reg   <= 1'b0;
      muldiv_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      t1_wait_reg <= (state_reg == T1);
      if (state_reg == T3) begin
        ra_reg     <= ir[RA_MSB:RA_LSB];
        rb_reg     <= ir[RB_MSB:RB_LSB];
        rc_reg     <= ir[RC_MSB:RC_LSB];
        alu_reg    <= dec_alu;
        unary_reg  <= dec_unary;
        muldiv_reg <= dec_muldiv;
        if (!dec_legal) illegal_reg <= 1'b1;
      end
    end
  end

  assign illegal = illegal_reg;

  always_comb begin
    state_next = state_reg;
    rout       = '0;
    rin        = '0;
    pc_out     = 1'b0;
    pc_in      = 1'b0;
    inc_pc     = 1'b0;
    mar_in     = 1'b0;
    ir_in      = 1'b0;
    mdr_read   = 1'b0;
    mdr_in     = 1'b0;
    mdr_out    = 1'b0;
    y_in       = 1'b0;
    z_in       = 1'b0;
    zlow_out   = 1'b0;
    zhigh_out  = 1'b0;
    lo_in      = 1'b0;
    hi_in      = 1'b0;
    alu_ctrl   = '0;
    instr_done = 1'b0;
    case (state_reg)
      IDLE: if (run) state_next = T0;
      T0: begin
        pc_out = 1'b1; mar_in = 1'b1; inc_pc = 1'b1; z_in = 1'b1;
        state_next = T1;
      end
      T1: begin
        // PC is reloaded only once even if memory keeps us waiting here
        zlow_out = 1'b1; pc_in = !t1_wait_reg; mdr_read = 1'b1; mdr_in = 1'b1;
        if (mem_rdy) state_next = T2;
      end
      T2: begin
        mdr_out = 1'b1; ir_in = 1'b1;
        state_next = T3;
      end
      T3: begin
        if (dec_legal) begin
          rout = dec_muldiv ? ir_ra_oh : ir_rb_oh;
          y_in = 1'b1;
          state_next = T4;
        end else begin
          state_next = ERR;
        end
      end
      T4: begin
        rout     = (muldiv_reg || unary_reg) ? rb_oh : rc_oh;
        alu_ctrl = alu_reg;
        z_in     = 1'b1;
        state_next = T5;
      end
      T5: begin
        zlow_out = 1'b1;
`ifdef CTRL_MULDIV_EN
        if (muldiv_reg) begin
          lo_in = 1'b1;
          state_next = T6;
        end else begin
          rin = ra_oh; instr_done = 1'b1;
          state_next = run ? T0 : IDLE;
        end
`else
        rin = ra_oh; instr_done = 1'b1;
        state_next = run ? T0 : IDLE;
`endif
      end
`ifdef CTRL_MULDIV_EN
      T6: begin
        zhigh_out = 1'b1; hi_in = 1'b1; instr_done = 1'b1;
        state_next = run ? T0 : IDLE;
      end
`endif
      ERR: state_next = ERR;
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer; honours CTRL_MULDIV_EN for the MUL scenario.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        clr, run, mem_rdy;
  logic [31:0] ir;
  logic [15:0] rout, rin;
  logic        pc_out, pc_in, inc_pc, mar_in, ir_in, mdr_read, mdr_in, mdr_out;
  logic        y_in, z_in, zlow_out, zhigh_out, lo_in, hi_in, instr_done, illegal;
  logic [11:0] alu_ctrl;

  int checks = 0;
  int failures = 0;

  control_sequencer dut (
    .clk(clk), .clr(clr), .run(run), .mem_rdy(mem_rdy), .ir(ir),
    .rout(rout), .rin(rin), .pc_out(pc_out), .pc_in(pc_in), .inc_pc(inc_pc),
    .mar_in(mar_in), .ir_in(ir_in), .mdr_read(mdr_read), .mdr_in(mdr_in),
    .mdr_out(mdr_out), .y_in(y_in), .z_in(z_in), .zlow_out(zlow_out),
    .zhigh_out(zhigh_out), .lo_in(lo_in), .hi_in(hi_in), .alu_ctrl(alu_ctrl),
    .instr_done(instr_done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Packed view of every output: {strobes[14:0], rout, rin, alu_ctrl, illegal}
  wire [14:0] strobes = {pc_out, pc_in, inc_pc, mar_in, ir_in, mdr_read, mdr_in, mdr_out,
                         y_in, z_in, zlow_out, zhigh_out, lo_in, hi_in, instr_done};
  wire [59:0] obs = {strobes, rout, rin, alu_ctrl, illegal};

  localparam logic [14:0] S_PC_OUT = 15'h4000, S_PC_IN = 15'h2000, S_INC_PC = 15'h1000;
  localparam logic [14:0] S_MAR_IN = 15'h0800, S_IR_IN = 15'h0400, S_MDR_RD = 15'h0200;
  localparam logic [14:0] S_MDR_IN = 15'h0100, S_MDR_OUT = 15'h0080, S_Y_IN = 15'h0040;
  localparam logic [14:0] S_Z_IN = 15'h0020, S_ZLOW = 15'h0010, S_ZHIGH = 15'h0008;
  localparam logic [14:0] S_LO_IN = 15'h0004, S_HI_IN = 15'h0002, S_DONE = 15'h0001;
  localparam logic [14:0] X_T0  = S_PC_OUT | S_MAR_IN | S_INC_PC | S_Z_IN;
  localparam logic [14:0] X_T1  = S_ZLOW | S_PC_IN | S_MDR_RD | S_MDR_IN;
  localparam logic [14:0] X_T1W = S_ZLOW | S_MDR_RD | S_MDR_IN;
  localparam logic [14:0] X_T2  = S_MDR_OUT | S_IR_IN;

  localparam logic [31:0] IR_SUB = 32'h4A92_0000;  // SUB R5,R2,R4

  function automatic logic [59:0] ex(input logic [14:0] s, input logic [15:0] ro,
                                     input logic [15:0] ri, input logic [11:0] a,
                                     input logic il);
    return {s, ro, ri, a, il};
  endfunction

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic do_clr;
    clr = 1'b1; run = 1'b0; mem_rdy = 1'b1;
    tick;
    clr = 1'b0;
    tick;
  endtask

  task automatic test_reset;
    clr = 1'b1; run = 1'b1; mem_rdy = 1'b1; ir = IR_SUB;
    for (int k = 0; k < 3; k++) begin
      tick;
      checks++;
      if (obs !== 60'd0) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d got=%h want=%h", k, obs, 60'd0);
      end
    end
    clr = 1'b0; run = 1'b0;
    tick;
  endtask

  task automatic test_sub;
    logic [59:0] exp [7];
    do_clr;
    ir = IR_SUB; mem_rdy = 1'b1; run = 1'b1;
    exp[0] = ex(X_T0, 16'h0, 16'h0, 12'h0, 1'b0);
    exp[1] = ex(X_T1, 16'h0, 16'h0, 12'h0, 1'b0);
    exp[2] = ex(X_T2, 16'h0, 16'h0, 12'h0, 1'b0);
    exp[3] = ex(S_Y_IN, 16'h0004, 16'h0, 12'h0, 1'b0);
    exp[4] = ex(S_Z_IN, 16'h0010, 16'h0, 12'h002, 1'b0);
    exp[5] = ex(S_ZLOW | S_DONE, 16'h0, 16'h0020, 12'h0, 1'b0);
    exp[6] = 60'd0;
    for (int k = 0; k < 7; k++) begin
      tick;
      if (k == 5) run = 1'b0;
      checks++;
      if (obs !== exp[k]) begin
        failures++;
        $display("FAIL sub_seq step=%0d got=%h want=%h", k, obs, exp[k]);
      end
    end
  endtask

  task automatic test_unary;
    logic [59:0] exp [6];
    do_clr;
    ir = {5'b10010, 4'd1, 4'd7, 4'd2, 15'd0};  // NEG R1,R7
    run = 1'b1;
    exp[0] = ex(X_T0, 16'h0, 16'h0, 12'h0, 1'b0);
    exp[1] = ex(X_T1, 16'h0, 16'h0, 12'h0, 1'b0);
    exp[2] = ex(X_T2, 16'h0, 16'h0, 12'h0, 1'b0);
    exp[3] = ex(S_Y_IN, 16'h0080, 16'h0, 12'h0, 1'b0);
    exp[4] = ex(S_Z_IN, 16'h0080, 16'h0, 12'h400, 1'b0);
    exp[5] = ex(S_ZLOW | S_DONE, 16'h0, 16'h0002, 12'h0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      tick;
      if (k == 5) run = 1'b0;
      checks++;
      if (obs !== exp[k]) begin
        failures++;
        $display("FAIL neg_seq step=%0d got=%h want=%h", k, obs, exp[k]);
      end
    end
    tick;
  endtask

  task automatic test_back_to_back;
    logic [59:0] exp [8];
    do_clr;
    ir = {5'b01000, 4'd0, 4'd1, 4'd15, 15'd0};  // ADD R0,R1,R15
    run = 1'b1;
    exp[0] = ex(X_T0, 16'h0, 16'h0, 12'h0, 1'b0);
    exp[1] = ex(X_T1, 16'h0, 16'h0, 12'h0, 1'b0);
    exp[2] = ex(X_T2, 16'h0, 16'h0, 12'h0, 1'b0);
    exp[3] = ex(S_Y_IN, 16'h0002, 16'h0, 12'h0, 1'b0);
    exp[4] = ex(S_Z_IN, 16'h8000, 16'h0, 12'h001, 1'b0);
    exp[5] = ex(S_ZLOW | S_DONE, 16'h0, 16'h0001, 12'h0, 1'b0);
    exp[6] = ex(X_T0, 16'h0, 16'h0, 12'h0, 1'b0);
    exp[7] = ex(X_T1, 16'h0, 16'h0, 12'h0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      tick;
      checks++;
      if (obs !== exp[k]) begin
        failures++;
        $display("FAIL b2b_seq step=%0d got=%h want=%h", k, obs, exp[k]);
      end
    end
    run = 1'b0;
  endtask

  task automatic test_mem_wait;
    logic [14:0] s;
    do_clr;
    ir = IR_SUB; run = 1'b1; mem_rdy = 1'b0;
    tick;
    checks++;
    if (obs !== ex(X_T0, 16'h0, 16'h0, 12'h0, 1'b0)) begin
      failures++;
      $display("FAIL wait_t0 got=%h want=%h", obs, ex(X_T0, 16'h0, 16'h0, 12'h0, 1'b0));
    end
    for (int k = 0; k < 4; k++) begin
      tick;
      if (k == 3) mem_rdy = 1'b1;
      s = (k == 0) ? X_T1 : X_T1W;
      checks++;
      if (obs !== ex(s, 16'h0, 16'h0, 12'h0, 1'b0)) begin
        failures++;
        $display("FAIL wait_t1 cyc=%0d got=%h want=%h", k, obs, ex(s, 16'h0, 16'h0, 12'h0, 1'b0));
      end
    end
    tick;
    run = 1'b0;
    checks++;
    if (obs !== ex(X_T2, 16'h0, 16'h0, 12'h0, 1'b0)) begin
      failures++;
      $display("FAIL wait_t2 got=%h want=%h", obs, ex(X_T2, 16'h0, 16'h0, 12'h0, 1'b0));
    end
    repeat (4) tick;
  endtask

  task automatic test_run_drop;
    int done_cnt, done_at;
    do_clr;
    ir = IR_SUB; run = 1'b1; mem_rdy = 1'b1;
    repeat (3) tick;           // T0, T1, T2
    run = 1'b0;
    done_cnt = 0; done_at = -1;
    for (int k = 0; k < 8; k++) begin
      tick;
      if (instr_done) begin done_cnt++; done_at = k; end
    end
    checks++;
    if (done_cnt !== 1) begin
      failures++;
      $display("FAIL rundrop_done_count got=%0d want=1", done_cnt);
    end
    checks++;
    if (done_at !== 2) begin
      failures++;
      $display("FAIL rundrop_done_cycle got=%0d want=2", done_at);
    end
    checks++;
    if (obs !== 60'd0) begin
      failures++;
      $display("FAIL rundrop_idle got=%h want=%h", obs, 60'd0);
    end
  endtask

  task automatic test_illegal;
    int bad;
    do_clr;
    ir = 32'hF800_0000; run = 1'b1; mem_rdy = 1'b1;
    repeat (4) tick;           // T0..T3
    checks++;
    if (obs !== 60'd0) begin
      failures++;
      $display("FAIL illegal_t3 got=%h want=%h", obs, 60'd0);
    end
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      tick;
      if (obs !== ex(15'h0, 16'h0, 16'h0, 12'h0, 1'b1)) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL illegal_err_hold bad_cycles=%0d want=0 last=%h", bad, obs);
    end
    clr = 1'b1;
    #1;
    checks++;
    if (obs !== 60'd0) begin
      failures++;
      $display("FAIL illegal_clr got=%h want=%h", obs, 60'd0);
    end
    tick;
    clr = 1'b0; ir = IR_SUB;
    tick;
    checks++;
    if (obs !== ex(X_T0, 16'h0, 16'h0, 12'h0, 1'b0)) begin
      failures++;
      $display("FAIL illegal_restart got=%h want=%h", obs, ex(X_T0, 16'h0, 16'h0, 12'h0, 1'b0));
    end
    run = 1'b0;
  endtask

  task automatic test_clr_mid;
    logic rin_seen;
    do_clr;
    ir = IR_SUB; run = 1'b1; mem_rdy = 1'b1;
    repeat (5) tick;           // T0..T4
    checks++;
    if (obs !== ex(S_Z_IN, 16'h0010, 16'h0, 12'h002, 1'b0)) begin
      failures++;
      $display("FAIL clrmid_t4 got=%h want=%h", obs, ex(S_Z_IN, 16'h0010, 16'h0, 12'h002, 1'b0));
    end
    clr = 1'b1;
    #1;
    checks++;
    if (obs !== 60'd0) begin
      failures++;
      $display("FAIL clrmid_async got=%h want=%h", obs, 60'd0);
    end
    rin_seen = 1'b0;
    tick;
    rin_seen = rin_seen | (|rin);
    clr = 1'b0;
    tick;
    rin_seen = rin_seen | (|rin);
    checks++;
    if (obs !== ex(X_T0, 16'h0, 16'h0, 12'h0, 1'b0)) begin
      failures++;
      $display("FAIL clrmid_restart got=%h want=%h", obs, ex(X_T0, 16'h0, 16'h0, 12'h0, 1'b0));
    end
    checks++;
    if (rin_seen !== 1'b0) begin
      failures++;
      $display("FAIL clrmid_no_rin got=%b want=0", rin_seen);
    end
    run = 1'b0;
  endtask

  task automatic test_muldiv;
`ifdef CTRL_MULDIV_EN
    logic [59:0] exp [5];
`endif
    do_clr;
    ir = {5'b10000, 4'd3, 4'd6, 4'd0, 15'd0};  // MUL R3,R6
    run = 1'b1; mem_rdy = 1'b1;
    repeat (3) tick;           // T0..T2
`ifdef CTRL_MULDIV_EN
    exp[0] = ex(S_Y_IN, 16'h0008, 16'h0, 12'h0, 1'b0);
    exp[1] = ex(S_Z_IN, 16'h0040, 16'h0, 12'h100, 1'b0);
    exp[2] = ex(S_ZLOW | S_LO_IN, 16'h0, 16'h0, 12'h0, 1'b0);
    exp[3] = ex(S_ZHIGH | S_HI_IN | S_DONE, 16'h0, 16'h0, 12'h0, 1'b0);
    exp[4] = 60'd0;
    for (int k = 0; k < 5; k++) begin
      tick;
      if (k == 3) run = 1'b0;
      checks++;
      if (obs !== exp[k]) begin
        failures++;
        $display("FAIL mul_seq step=%0d got=%h want=%h", k, obs, exp[k]);
      end
    end
`else
    tick;
    checks++;
    if (obs !== 60'd0) begin
      failures++;
      $display("FAIL mul_t3_nostrobe got=%h want=%h", obs, 60'd0);
    end
    tick;
    checks++;
    if (obs !== ex(15'h0, 16'h0, 16'h0, 12'h0, 1'b1)) begin
      failures++;
      $display("FAIL mul_illegal got=%h want=%h", obs, ex(15'h0, 16'h0, 16'h0, 12'h0, 1'b1));
    end
    run = 1'b0;
`endif
  endtask

  initial begin
    clr = 1'b1; run = 1'b0; mem_rdy = 1'b1; ir = 32'd0;
    test_reset;
    test_sub;
    test_unary;
    test_back_to_back;
    test_mem_wait;
    test_run_drop;
    test_illegal;
    test_clr_mid;
    test_muldiv;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
